// File: rtl/overlay_pkg.sv
// Shared types for the overlay fetch arbiter: FSM states and the 4-4-4-4 overlay pixel.
package overlay_pkg;

    localparam int PIX_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } fsm_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } ovl_pix_t;

endpackage

// File: rtl/overlay_fifo.sv
// First-word-fall-through prefetch FIFO; flush empties it in one cycle and beats push/pop.
module overlay_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == L_DEPTH);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/overlay_fetch_arbiter.sv
// Single-channel SDRAM arbiter for overlay download writes and per-pixel prefetch reads.
// Optional per-frame statistics outputs are built when OVERLAY_STATS_EN is defined.
module overlay_fetch_arbiter
    import overlay_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              sd_req,
    output logic              sd_rnw,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_din,
    input  logic [31:0]       sd_dout,
    input  logic              sd_ack,
    output logic [PIX_W-1:0]  pix_data,
    output logic              underrun,
    output logic              dl_overrun
`ifdef OVERLAY_STATS_EN
    ,
    output logic [15:0]       stat_underruns,
    output logic [15:0]       stat_reads
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]    L_DEPTH   = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] L_RD_STEP = ADDR_W'(2);

    fsm_e              r_state;
    fsm_e              w_state_nxt;
    logic              r_vblank_d;
    logic              r_dl_active_d;
    logic [7:0]        r_lo_byte;
    logic              r_wr_pending;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_discard;
    logic              r_sd_req;
    logic              r_sd_rnw;
    logic [ADDR_W-1:0] r_sd_addr;
    logic [15:0]       r_sd_din;
    ovl_pix_t          r_pix;
    logic              r_half_sel;
    logic              r_underrun;
    logic              r_dl_overrun;

    logic              w_frame_start;
    logic              w_dl_start;
    logic              w_flush;
    logic              w_issue_wr;
    logic              w_issue_rd;
    logic              w_outstanding;
    logic [CNT_W:0]    w_fill;
    logic              w_pix_en;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [31:0]       w_fifo_dout;
    logic [CNT_W-1:0]  w_count;

    assign w_frame_start = vblank & ~r_vblank_d;
    assign w_dl_start    = dl_active & ~r_dl_active_d;
    assign w_flush       = w_frame_start | w_dl_start;
    assign w_outstanding = ((r_state == RD_REQ) || (r_state == RD_WAIT)) && !r_discard;
    assign w_fill        = {1'b0, w_count} + {{CNT_W{1'b0}}, w_outstanding};
    assign w_pix_en      = ce_pix & ~hblank & ~vblank & enable & ~dl_active;
    // A flush in the ack cycle wins, so that read's data never lands in the new frame.
    assign w_push        = (r_state == RD_WAIT) & sd_ack & ~r_discard & ~w_flush;
    assign w_pop         = w_pix_en & ~w_empty & r_half_sel;

    assign sd_req     = r_sd_req;
    assign sd_rnw     = r_sd_rnw;
    assign sd_addr    = r_sd_addr;
    assign sd_din     = r_sd_din;
    assign pix_data   = r_pix;
    assign underrun   = r_underrun;
    assign dl_overrun = r_dl_overrun;

    overlay_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk_sys),
        .reset (reset),
        .flush (w_flush),
        .push  (w_push),
        .din   (sd_dout),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Edge detectors for frame start and download start.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vblank_d    <= 1'b0;
            r_dl_active_d <= 1'b0;
        end else begin
            r_vblank_d    <= vblank;
            r_dl_active_d <= dl_active;
        end
    end

    // Next-state logic; new reads are held off in a flush cycle so they use the restarted address.
    always_comb begin
        w_state_nxt = r_state;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_wr_pending) begin
                    w_state_nxt = WR_REQ;
                    w_issue_wr  = 1'b1;
                end else if (enable && !dl_active && !w_flush && !w_full && (w_fill < L_DEPTH)) begin
                    w_state_nxt = RD_REQ;
                    w_issue_rd  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR_REQ:  w_state_nxt = WR_WAIT;
            WR_WAIT: w_state_nxt = sd_ack ? IDLE : WR_WAIT;
            RD_REQ:  w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = sd_ack ? IDLE : RD_WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered SDRAM command; sd_req is high exactly while in a *_REQ state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sd_req  <= 1'b0;
            r_sd_rnw  <= 1'b0;
            r_sd_addr <= '0;
            r_sd_din  <= '0;
            r_rd_addr <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sd_req <= w_issue_wr | w_issue_rd;
            if (w_issue_wr) begin
                r_sd_rnw  <= 1'b0;
                r_sd_addr <= r_wr_addr;
                r_sd_din  <= r_wr_data;
            end else if (w_issue_rd) begin
                r_sd_rnw  <= 1'b1;
                r_sd_addr <= r_rd_addr;
            end
            if (w_frame_start) begin
                r_rd_addr <= '0;
            end else if (w_issue_rd) begin
                r_rd_addr <= r_rd_addr + L_RD_STEP;
            end
            if ((r_state == RD_WAIT) && sd_ack) begin
                r_discard <= 1'b0;
            end else if (w_flush && ((r_state == RD_REQ) || (r_state == RD_WAIT))) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Download byte packing into 16-bit words with a single pending-write slot.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_lo_byte    <= '0;
            r_wr_pending <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_dl_overrun <= 1'b0;
        end else begin
            if ((r_state == WR_WAIT) && sd_ack) begin
                r_wr_pending <= 1'b0;
            end
            if (w_dl_start) begin
                r_dl_overrun <= 1'b0;
            end
            if (dl_wr && !dl_addr[0]) begin
                r_lo_byte <= dl_data;
            end else if (dl_wr && r_wr_pending) begin
                r_dl_overrun <= 1'b1;
            end else if (dl_wr) begin
                r_wr_data    <= {dl_data, r_lo_byte};
                r_wr_addr    <= ADDR_W'(dl_addr[24:1]);
                r_wr_pending <= 1'b1;
            end
        end
    end

    // Pixel output: low half then high half of each FIFO word, popping after the high half.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_pix      <= '0;
            r_half_sel <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_pix_en) begin
                if (!w_empty) begin
                    r_pix      <= r_half_sel ? ovl_pix_t'(w_fifo_dout[31:16])
                                             : ovl_pix_t'(w_fifo_dout[15:0]);
                    r_half_sel <= ~r_half_sel;
                end else begin
                    r_pix      <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (!enable || dl_active) begin
                r_pix <= '0;
            end
            if (w_frame_start) begin
                r_half_sel <= 1'b0;
                r_underrun <= 1'b0;
            end
        end
    end

`ifdef OVERLAY_STATS_EN
    logic [15:0] r_stat_underruns;
    logic [15:0] r_stat_reads;

    assign stat_underruns = r_stat_underruns;
    assign stat_reads     = r_stat_reads;

    // Per-frame saturating counters of underrun pixels and issued reads.
    always_ff @(posedge clk_sys) begin
        if (reset || w_frame_start) begin
            r_stat_underruns <= '0;
            r_stat_reads     <= '0;
        end else begin
            if (w_pix_en && w_empty && (r_stat_underruns != 16'hFFFF)) begin
                r_stat_underruns <= r_stat_underruns + 16'd1;
            end
            if (w_issue_rd && (r_stat_reads != 16'hFFFF)) begin
                r_stat_reads <= r_stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule
